// File: rtl/sprite_pkg.sv
// Shared sprite-sheet definitions: sheet geometry, animation state encoding and
// the compass-orientation to sheet-row table, reused by the icon renderers.
package sprite_pkg;

    localparam int SHEET_COLS = 3;
    localparam int SHEET_ROWS = 8;

    typedef enum logic [1:0] {
        ST_STILL = 2'd0,
        ST_FWD   = 2'd1,
        ST_REV   = 2'd2
    } anim_state_e;

    // Sheet rows are not in compass order; this maps N..NW onto them.
    function automatic logic [2:0] orient_to_row(input logic [2:0] orient);
        logic [2:0] row;
        case (orient)
            3'd0:    row = 3'd1;
            3'd1:    row = 3'd7;
            3'd2:    row = 3'd3;
            3'd3:    row = 3'd5;
            3'd4:    row = 3'd0;
            3'd5:    row = 3'd4;
            3'd6:    row = 3'd2;
            default: row = 3'd6;
        endcase
        return row;
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Walk-cycle animation controller: selects the sprite-sheet frame once per
// video frame and publishes its RAM base address two cycles after vsync.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_STILL | robot stationary, standing frame (column 1)
// ST_FWD   | walking, column stepping upward toward 2
// ST_REV   | walking, column stepping downward toward 0
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_COLS     = 34,
    parameter int unsigned SPRITE_ROWS     = 34,
    parameter int unsigned FRAMES_PER_STEP = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_start,
    input  logic        enable,
    input  logic [7:0]  bot_info,
    output logic [2:0]  frame_row,
    output logic [1:0]  frame_col,
    output logic [15:0] base_addr,
    output logic        frame_update
);

    localparam logic [7:0]  RELOAD     = 8'(FRAMES_PER_STEP - 1);
    localparam logic [15:0] ROW_STRIDE = 16'(SHEET_COLS * SPRITE_COLS * SPRITE_ROWS);
    localparam logic [15:0] COL_STRIDE = 16'(SPRITE_COLS);
    localparam logic [15:0] RESET_BASE = ROW_STRIDE + COL_STRIDE;

    anim_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  frame_row_q, frame_row_d;
    logic [1:0]  frame_col_q, frame_col_d;
    logic        upd_pend_q, upd_pend_d;
    logic [15:0] base_addr_q, base_addr_d;
    logic        frame_update_q, frame_update_d;
    logic        moving;
    logic        unused_info_bit;

    assign moving          = (bot_info[7:4] != 4'd0);
    assign unused_info_bit = bot_info[3];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        frame_row_d    = frame_row_q;
        frame_col_d    = frame_col_q;
        upd_pend_d     = upd_pend_q;
        base_addr_d    = base_addr_q;
        frame_update_d = frame_update_q;

        if (enable) begin
            // The address stage trails the row/col stage by one cycle and only
            // moves when the previous vsync really changed the frame.
            frame_update_d = upd_pend_q;
            upd_pend_d     = 1'b0;
            if (upd_pend_q) begin
                base_addr_d = 16'(frame_row_q) * ROW_STRIDE + 16'(frame_col_q) * COL_STRIDE;
            end

            if (vsync_start) begin
                frame_row_d = orient_to_row(bot_info[2:0]);
                case (state_q)
                    ST_STILL: begin
                        frame_col_d = 2'd1;
                        if (moving) begin
                            state_d = ST_FWD;
                            cnt_d   = RELOAD;
                        end
                    end
                    ST_FWD: begin
                        if (!moving) begin
                            state_d     = ST_STILL;
                            frame_col_d = 2'd1;
                            cnt_d       = RELOAD;
                        end else if (cnt_q == 8'd0) begin
                            frame_col_d = frame_col_q + 2'd1;
                            cnt_d       = RELOAD;
                            if (frame_col_q == 2'd1) state_d = ST_REV;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                    ST_REV: begin
                        if (!moving) begin
                            state_d     = ST_STILL;
                            frame_col_d = 2'd1;
                            cnt_d       = RELOAD;
                        end else if (cnt_q == 8'd0) begin
                            frame_col_d = frame_col_q - 2'd1;
                            cnt_d       = RELOAD;
                            if (frame_col_q == 2'd1) state_d = ST_FWD;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                    default: begin
                        state_d     = ST_STILL;
                        frame_col_d = 2'd1;
                        cnt_d       = RELOAD;
                    end
                endcase
                upd_pend_d = (frame_row_d != frame_row_q) || (frame_col_d != frame_col_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_STILL;
            cnt_q          <= RELOAD;
            frame_row_q    <= 3'd1;
            frame_col_q    <= 2'd1;
            upd_pend_q     <= 1'b0;
            base_addr_q    <= RESET_BASE;
            frame_update_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            frame_row_q    <= frame_row_d;
            frame_col_q    <= frame_col_d;
            upd_pend_q     <= upd_pend_d;
            base_addr_q    <= base_addr_d;
            frame_update_q <= frame_update_d;
        end
    end

    assign frame_row    = frame_row_q;
    assign frame_col    = frame_col_q;
    assign base_addr    = base_addr_q;
    assign frame_update = frame_update_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Bench: three controllers (FRAMES_PER_STEP 8, 2, 1) share one stimulus stream
// and are compared every cycle against a walk-cycle model, plus literal pins.
module tb_sprite_anim_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_start = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  bot_info = 8'h00;
    logic [2:0]  row_o [3];
    logic [1:0]  col_o [3];
    logic [15:0] base_o [3];
    logic        upd_o [3];

    int total = 0;
    int bad = 0;
    bit chk_on = 0;
    int upd_cnt2 = 0;

    int fps_tab [3] = '{8, 2, 1};
    int row_tab [8] = '{1, 7, 3, 5, 0, 4, 2, 6};

    // model state per instance; m_k counts qualified moving vsyncs since walking began
    int m_k [3];
    int m_row [3];
    int m_col [3];
    int m_base [3];
    int m_upd [3];
    int m_pend [3];

    always #5 clk = ~clk;

    sprite_anim_ctrl #(.FRAMES_PER_STEP(8)) u8 (
        .clk(clk), .reset(reset), .vsync_start(vsync_start), .enable(enable), .bot_info(bot_info),
        .frame_row(row_o[0]), .frame_col(col_o[0]), .base_addr(base_o[0]), .frame_update(upd_o[0]));
    sprite_anim_ctrl #(.FRAMES_PER_STEP(2)) u2 (
        .clk(clk), .reset(reset), .vsync_start(vsync_start), .enable(enable), .bot_info(bot_info),
        .frame_row(row_o[1]), .frame_col(col_o[1]), .base_addr(base_o[1]), .frame_update(upd_o[1]));
    sprite_anim_ctrl #(.FRAMES_PER_STEP(1)) u1 (
        .clk(clk), .reset(reset), .vsync_start(vsync_start), .enable(enable), .bot_info(bot_info),
        .frame_row(row_o[2]), .frame_col(col_o[2]), .base_addr(base_o[2]), .frame_update(upd_o[2]));

    // Walk cycle as a triangle wave: step s = k / fps, column = 1,2,1,0 repeating.
    function automatic int col_of(input int k, input int fps);
        int pat;
        if (k < 0) return 1;
        pat = (k / fps) % 4;
        case (pat)
            0: return 1;
            1: return 2;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int nr, nc;
            if (reset) begin
                m_k[i] = -1; m_row[i] = 1; m_col[i] = 1;
                m_base[i] = 3502; m_upd[i] = 0; m_pend[i] = 0;
            end else if (enable) begin
                m_upd[i] = m_pend[i];
                if (m_pend[i] != 0) m_base[i] = m_row[i] * 3 * 34 * 34 + m_col[i] * 34;
                m_pend[i] = 0;
                if (vsync_start) begin
                    nr = row_tab[bot_info[2:0]];
                    if (bot_info[7:4] != 4'd0) m_k[i] = (m_k[i] < 0) ? 0 : m_k[i] + 1;
                    else m_k[i] = -1;
                    nc = col_of(m_k[i], fps_tab[i]);
                    m_pend[i] = (nr != m_row[i] || nc != m_col[i]) ? 1 : 0;
                    m_row[i] = nr;
                    m_col[i] = nc;
                end
            end
        end
    end

    task automatic cmp(input string name, input int inst, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", name, inst, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                cmp("frame_row", i, int'(row_o[i]), m_row[i]);
                cmp("frame_col", i, int'(col_o[i]), m_col[i]);
                cmp("base_addr", i, int'(base_o[i]), m_base[i]);
                cmp("frame_update", i, int'(upd_o[i]), m_upd[i]);
            end
            if (upd_o[1]) upd_cnt2++;
        end
    end

    task automatic pulse(input logic [7:0] bi, input logic en, input logic rs, input int gap);
        bot_info = bi;
        enable = en;
        @(negedge clk);
        vsync_start = 1'b1;
        reset = rs;
        @(negedge clk);
        vsync_start = 1'b0;
        reset = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seq2 [10] = '{1, 1, 2, 2, 1, 1, 0, 0, 1, 1};
        int snap;
        logic [7:0] bi;

        @(posedge clk);
        @(negedge clk);
        chk_on = 1;
        do_reset();
        cmp("rst_row", 1, int'(row_o[1]), 1);
        cmp("rst_col", 1, int'(col_o[1]), 1);
        cmp("rst_base", 1, int'(base_o[1]), 3502);
        cmp("rst_upd", 1, int'(upd_o[1]), 0);

        // standing facing S: one address update only
        snap = upd_cnt2;
        for (int p = 0; p < 3; p++) pulse(8'h04, 1'b1, 1'b0, 3);
        cmp("still_row", 1, int'(row_o[1]), 0);
        cmp("still_col", 1, int'(col_o[1]), 1);
        cmp("still_base", 1, int'(base_o[1]), 34);
        cmp("still_upd_count", 1, upd_cnt2 - snap, 1);

        // walking E, fps=2 column sequence
        do_reset();
        for (int p = 0; p < 10; p++) begin
            pulse(8'h12, 1'b1, 1'b0, 3);
            cmp("walk_col", 1, int'(col_o[1]), seq2[p]);
            cmp("walk_row", 1, int'(row_o[1]), 3);
        end

        // stop while at column 2
        do_reset();
        for (int p = 0; p < 3; p++) pulse(8'h12, 1'b1, 1'b0, 3);
        cmp("pre_stop_col", 1, int'(col_o[1]), 2);
        pulse(8'h02, 1'b1, 1'b0, 3);
        cmp("stop_col", 1, int'(col_o[1]), 1);
        cmp("stop_base", 1, int'(base_o[1]), 10438);

        // freeze with enable low, then resume from the held count
        do_reset();
        pulse(8'h12, 1'b1, 1'b0, 3);
        pulse(8'h12, 1'b1, 1'b0, 3);
        for (int p = 0; p < 5; p++) pulse(8'h12, 1'b0, 1'b0, 3);
        cmp("frz_col", 1, int'(col_o[1]), 1);
        cmp("frz_base", 1, int'(base_o[1]), 10438);
        pulse(8'h12, 1'b1, 1'b0, 3);
        cmp("resume_col", 1, int'(col_o[1]), 2);

        // reset coincident with vsync while reversing
        do_reset();
        for (int p = 0; p < 4; p++) pulse(8'h12, 1'b1, 1'b0, 3);
        @(negedge clk);
        vsync_start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        vsync_start = 1'b0;
        reset = 1'b0;
        cmp("rstv_col", 1, int'(col_o[1]), 1);
        cmp("rstv_row", 1, int'(row_o[1]), 1);
        cmp("rstv_upd", 1, int'(upd_o[1]), 0);
        @(negedge clk);
        cmp("rstv_upd2", 1, int'(upd_o[1]), 0);
        cmp("rstv_base", 1, int'(base_o[1]), 3502);

        // fps=1: column advances every vsync
        do_reset();
        pulse(8'hF7, 1'b1, 1'b0, 3);
        cmp("f1_row", 2, int'(row_o[2]), 6);
        cmp("f1_col_a", 2, int'(col_o[2]), 1);
        pulse(8'hF7, 1'b1, 1'b0, 3);
        cmp("f1_col_b", 2, int'(col_o[2]), 2);
        cmp("f1_base", 2, int'(base_o[2]), 20876);
        pulse(8'hF7, 1'b1, 1'b0, 3);
        cmp("f1_col_c", 2, int'(col_o[2]), 1);
        pulse(8'hF7, 1'b1, 1'b0, 3);
        cmp("f1_col_d", 2, int'(col_o[2]), 0);

        // randomized run, checked every cycle by the model
        bi = 8'h12;
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                bi = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) bi[7:4] = 4'd0;
            end
            pulse(bi, ($urandom_range(0, 6) != 0), ($urandom_range(0, 49) == 0),
                  int'($urandom_range(1, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
